// File: rtl/game_ctrl_if.sv
// Signal bundle between the snake game controller and its neighbours
// (VGA timing, key, tail, renderer and seven-segment stages).
interface game_ctrl_if;
   logic       iFrame_start;
   logic       iStart;
   logic [1:0] iDir;
   logic       iHit_self;
   logic [2:0] oGame_state;
   logic [5:0] oHead_x;
   logic [5:0] oHead_y;
   logic [5:0] oFood_x;
   logic [5:0] oFood_y;
   logic [7:0] oScore;
   logic       oStep;
   logic       oEat;

   modport master (
      output iFrame_start, iStart, iDir, iHit_self,
      input  oGame_state, oHead_x, oHead_y, oFood_x, oFood_y, oScore, oStep, oEat
   );

   modport slave (
      input  iFrame_start, iStart, iDir, iHit_self,
      output oGame_state, oHead_x, oHead_y, oFood_x, oFood_y, oScore, oStep, oEat
   );
endinterface

// File: rtl/game_ctrl.sv
// Snake game controller: game FSM, frame-paced head stepping, collision
// detection, scoring and LFSR-driven food placement.
module game_ctrl #(
   parameter int FRAMES_PER_STEP = 8,
   parameter int GRID_W          = 40,
   parameter int GRID_H          = 30,
   parameter int WIN_SCORE       = 99
) (
   input logic        vga_clk,
   input logic        sys_rst_n,
   game_ctrl_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE = 3'd0, S_PLAY = 3'd1, S_OVER = 3'd2, S_WON = 3'd3} state_t;
   typedef enum logic [1:0] {D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11} dir_t;

   localparam int                CNT_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
   localparam logic [5:0]        HOME_X    = 6'd20;
   localparam logic [5:0]        HOME_Y    = 6'd15;
   localparam logic [5:0]        FOOD0_X   = 6'd30;
   localparam logic [5:0]        FOOD0_Y   = 6'd15;
   localparam logic [15:0]       LFSR_SEED = 16'hACE1;
   localparam logic [5:0]        GRID_W6   = 6'(GRID_W);
   localparam logic [5:0]        GRID_H6   = 6'(GRID_H);
   localparam logic signed [6:0] MAX_X     = 7'(GRID_W - 1);
   localparam logic signed [6:0] MAX_Y     = 7'(GRID_H - 1);
   localparam logic [7:0]        WIN8      = 8'(WIN_SCORE);

   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic [5:0]       head_x_q, head_x_d, head_y_q, head_y_d;
   logic [5:0]       food_x_q, food_x_d, food_y_q, food_y_d;
   logic [7:0]       score_q, score_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             step_q, step_d, eat_q, eat_d;

   dir_t              req_dir, new_dir;
   logic signed [6:0] nx, ny;
   logic [5:0]        rnd_x, rnd_y;
   logic [7:0]        score_inc;
   logic              step_eval, collision, ate;

   // Head arithmetic is one bit wider and signed so stepping off the
   // left/top edge reads as -1 rather than wrapping into range.
   always_comb begin
      req_dir = dir_t'(bus.iDir);
      new_dir = ((req_dir[1] == dir_q[1]) && (req_dir[0] != dir_q[0])) ? dir_q : req_dir;
      nx = $signed({1'b0, head_x_q});
      ny = $signed({1'b0, head_y_q});
      case (new_dir)
         D_UP:    ny = ny - 7'sd1;
         D_DOWN:  ny = ny + 7'sd1;
         D_LEFT:  nx = nx - 7'sd1;
         D_RIGHT: nx = nx + 7'sd1;
      endcase
      collision = (nx < 7'sd0) || (nx > MAX_X) || (ny < 7'sd0) || (ny > MAX_Y) || bus.iHit_self;
      ate       = (nx[5:0] == food_x_q) && (ny[5:0] == food_y_q);
      score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
      step_eval = (state_q == S_PLAY) && bus.iFrame_start && (frame_cnt_q == CNT_LAST);

      rnd_x = lfsr_q[5:0];
      if (rnd_x >= GRID_W6) rnd_x = rnd_x - GRID_W6;
      rnd_y = lfsr_q[11:6];
      if (rnd_y >= GRID_H6) rnd_y = rnd_y - GRID_H6;
      if (rnd_y >= GRID_H6) rnd_y = rnd_y - GRID_H6;
   end

   // NOTE: every next-state value defaults to its register first, so no branch can infer a latch.
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      head_x_d    = head_x_q;
      head_y_d    = head_y_q;
      food_x_d    = food_x_q;
      food_y_d    = food_y_q;
      score_d     = score_q;
      frame_cnt_d = frame_cnt_q;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      step_d      = 1'b0;
      eat_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.iStart) begin
               state_d     = S_PLAY;
               head_x_d    = HOME_X;
               head_y_d    = HOME_Y;
               dir_d       = D_RIGHT;
               score_d     = 8'd0;
               food_x_d    = FOOD0_X;
               food_y_d    = FOOD0_Y;
               frame_cnt_d = '0;
            end
         end
         S_PLAY: begin
            if (bus.iFrame_start)
               frame_cnt_d = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
            if (step_eval) begin
               dir_d = new_dir;
               if (collision) begin
                  state_d = S_OVER;
               end else begin
                  head_x_d = nx[5:0];
                  head_y_d = ny[5:0];
                  step_d   = 1'b1;
                  if (ate) begin
                     score_d  = score_inc;
                     eat_d    = 1'b1;
                     food_x_d = rnd_x;
                     food_y_d = rnd_y;
                     if (score_inc == WIN8) state_d = S_WON;
                  end
               end
            end
         end
         S_OVER, S_WON: begin
            if (bus.iStart) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         dir_q       <= D_RIGHT;
         head_x_q    <= HOME_X;
         head_y_q    <= HOME_Y;
         food_x_q    <= FOOD0_X;
         food_y_q    <= FOOD0_Y;
         score_q     <= 8'd0;
         frame_cnt_q <= '0;
         lfsr_q      <= LFSR_SEED;
         step_q      <= 1'b0;
         eat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         head_x_q    <= head_x_d;
         head_y_q    <= head_y_d;
         food_x_q    <= food_x_d;
         food_y_q    <= food_y_d;
         score_q     <= score_d;
         frame_cnt_q <= frame_cnt_d;
         lfsr_q      <= lfsr_d;
         step_q      <= step_d;
         eat_q       <= eat_d;
      end
   end

   assign bus.oGame_state = state_q;
   assign bus.oHead_x     = head_x_q;
   assign bus.oHead_y     = head_y_q;
   assign bus.oFood_x     = food_x_q;
   assign bus.oFood_y     = food_y_q;
   assign bus.oScore      = score_q;
   assign bus.oStep       = step_q;
   assign bus.oEat        = eat_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected events, a monitor
// pops and compares whenever the DUT steps, changes state or a snapshot is requested.
module tb_game_ctrl;

   localparam int         FPS = 8;
   localparam logic [1:0] UP = 2'b00, DN = 2'b01, LT = 2'b10, RT = 2'b11;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [5:0] hx, hy, fx, fy;
      logic [7:0] sc;
      logic       stp, eat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   game_ctrl_if bus ();

   game_ctrl #(.FRAMES_PER_STEP(FPS), .GRID_W(40), .GRID_H(30), .WIN_SCORE(2)) dut (
      .vga_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic       sample_req = 1'b0;
   logic [2:0] prev_st = 3'd0;

   // Reference game model
   logic [15:0] lfsr_m;
   int          m_st, m_hx, m_hy, m_fx, m_fy, m_sc;
   logic [1:0]  m_dir;
   int          dx, dy;

   always @(posedge clk)
      lfsr_m <= !rst_n ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

   task automatic check_event();
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got st=%0d head=(%0d,%0d) step=%0b eat=%0b, required no event",
                  bus.oGame_state, bus.oHead_x, bus.oHead_y, bus.oStep, bus.oEat);
      end else begin
         e = sb.pop_front();
         if (bus.oGame_state !== e.st || bus.oHead_x !== e.hx || bus.oHead_y !== e.hy ||
             bus.oFood_x !== e.fx || bus.oFood_y !== e.fy || bus.oScore !== e.sc ||
             bus.oStep !== e.stp || bus.oEat !== e.eat) begin
            n_err++;
            $display("FAIL %s: got st=%0d head=(%0d,%0d) food=(%0d,%0d) score=%0d step=%0b eat=%0b, required st=%0d head=(%0d,%0d) food=(%0d,%0d) score=%0d step=%0b eat=%0b",
                     e.tag, bus.oGame_state, bus.oHead_x, bus.oHead_y, bus.oFood_x, bus.oFood_y,
                     bus.oScore, bus.oStep, bus.oEat, e.st, e.hx, e.hy, e.fx, e.fy, e.sc, e.stp, e.eat);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.oStep || bus.oEat || bus.oGame_state !== prev_st || sample_req)
            check_event();
      end
      prev_st = bus.oGame_state;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int st, hx, hy, fx, fy, sc, input logic stp, eat);
      exp_t e;
      e.tag = tag; e.st = 3'(st); e.hx = 6'(hx); e.hy = 6'(hy);
      e.fx = 6'(fx); e.fy = 6'(fy); e.sc = 8'(sc); e.stp = stp; e.eat = eat;
      sb.push_back(e);
   endtask

   task automatic snap(input string tag, input int st, hx, hy, sc);
      push(tag, st, hx, hy, m_fx, m_fy, sc, 1'b0, 1'b0);
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick();
   endtask

   task automatic model_home();
      m_hx = 20; m_hy = 15; m_dir = RT; m_sc = 0; m_fx = 30; m_fy = 15;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      m_st = 0;
      model_home();
      tick();
   endtask

   task automatic start_game(input logic with_frame);
      bus.iStart = 1'b1;
      bus.iFrame_start = with_frame;
      if (m_st == 0) begin
         model_home();
         m_st = 1;
         push("start", 1, 20, 15, 30, 15, 0, 1'b0, 1'b0);
      end else if (m_st >= 2) begin
         m_st = 0;
         push("to_idle", 0, m_hx, m_hy, m_fx, m_fy, m_sc, 1'b0, 1'b0);
      end
      tick();
      bus.iStart = 1'b0;
      bus.iFrame_start = 1'b0;
      tick();
   endtask

   task automatic model_step(input logic [1:0] d, input logic hit);
      logic [1:0] nd;
      int nx, ny;
      logic eat;
      logic [5:0] rx, ry;
      if (m_st != 1) return;
      nd = ((d[1] == m_dir[1]) && (d[0] != m_dir[0])) ? m_dir : d;
      m_dir = nd;
      nx = m_hx; ny = m_hy;
      case (nd)
         UP: ny = ny - 1;
         DN: ny = ny + 1;
         LT: nx = nx - 1;
         default: nx = nx + 1;
      endcase
      if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30 || hit) begin
         m_st = 2;
         push("collide", 2, m_hx, m_hy, m_fx, m_fy, m_sc, 1'b0, 1'b0);
      end else begin
         eat = (nx == m_fx) && (ny == m_fy);
         m_hx = nx; m_hy = ny;
         if (eat) begin
            if (m_sc < 255) m_sc = m_sc + 1;
            rx = lfsr_m[5:0];
            if (rx >= 6'd40) rx = rx - 6'd40;
            ry = lfsr_m[11:6];
            if (ry >= 6'd30) ry = ry - 6'd30;
            if (ry >= 6'd30) ry = ry - 6'd30;
            m_fx = rx; m_fy = ry;
            if (m_sc == 2) m_st = 3;
         end
         push(eat ? "eat" : "step", m_st, m_hx, m_hy, m_fx, m_fy, m_sc, 1'b1, eat);
      end
   endtask

   task automatic do_step(input logic [1:0] d, input logic hit, input int start_at);
      for (int i = 0; i < FPS; i++) begin
         bus.iDir = d;
         bus.iFrame_start = 1'b1;
         bus.iStart = (i == start_at);
         bus.iHit_self = hit && (i == FPS - 1);
         if (i == FPS - 1) model_step(d, hit);
         tick();
         bus.iFrame_start = 1'b0;
         bus.iStart = 1'b0;
         bus.iHit_self = 1'b0;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required end within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.iFrame_start = 1'b0;
      bus.iStart = 1'b0;
      bus.iDir = RT;
      bus.iHit_self = 1'b0;
      m_st = 0;
      model_home();
      tick();

      // Reset values, then one step right
      apply_reset();
      snap("reset_state", 0, 20, 15, 0);
      start_game(1'b0);
      do_step(RT, 1'b0, -1);
      snap("first_step", 1, 21, 15, 0);

      // Reverse request ignored
      apply_reset();
      start_game(1'b0);
      do_step(LT, 1'b0, -1);
      snap("reverse_ignored", 1, 21, 15, 0);

      // Start coincident with a frame is not counted; iStart inside PLAY is inert
      apply_reset();
      start_game(1'b1);
      do_step(DN, 1'b0, 3);
      snap("start_frame_uncounted", 1, 20, 16, 0);

      // Walk to (0,5), then off the left edge
      apply_reset();
      start_game(1'b0);
      repeat (10) do_step(UP, 1'b0, -1);
      repeat (20) do_step(LT, 1'b0, -1);
      snap("at_left_edge", 1, 0, 5, 0);
      do_step(LT, 1'b0, -1);
      snap("over_left_edge", 2, 0, 5, 0);
      start_game(1'b0);
      snap("idle_after_over", 0, 0, 5, 0);

      // Self hit with in-range next head
      start_game(1'b0);
      do_step(UP, 1'b1, -1);
      snap("self_hit_over", 2, 20, 15, 0);
      start_game(1'b0);

      // Eat initial food, then chase the LFSR food to win at score 2
      apply_reset();
      start_game(1'b0);
      repeat (9) do_step(RT, 1'b0, -1);
      snap("before_eat", 1, 29, 15, 0);
      do_step(RT, 1'b0, -1);
      dx = m_fx - m_hx;
      dy = m_fy - m_hy;
      if (dx == 0 && dy == 0) begin
         do_step(UP, 1'b0, -1);
         do_step(LT, 1'b0, -1);
         do_step(DN, 1'b0, -1);
         do_step(RT, 1'b0, -1);
      end else if (dy != 0) begin
         repeat (dy < 0 ? -dy : dy) do_step(dy < 0 ? UP : DN, 1'b0, -1);
         repeat (dx < 0 ? -dx : dx) do_step(dx < 0 ? LT : RT, 1'b0, -1);
      end else if (dx > 0) begin
         repeat (dx) do_step(RT, 1'b0, -1);
      end else begin
         do_step(UP, 1'b0, -1);
         repeat (-dx) do_step(LT, 1'b0, -1);
         do_step(DN, 1'b0, -1);
      end
      do_step(RT, 1'b0, -1);
      do_step(UP, 1'b0, -1);
      snap("won_frozen", 3, m_hx, m_hy, 2);

      // Reset asserted on the step-evaluation cycle
      start_game(1'b0);
      start_game(1'b0);
      for (int i = 0; i < FPS - 1; i++) begin
         bus.iFrame_start = 1'b1;
         tick();
         bus.iFrame_start = 1'b0;
         tick();
      end
      bus.iFrame_start = 1'b1;
      bus.iDir = DN;
      rst_n = 1'b0;
      tick();
      bus.iFrame_start = 1'b0;
      tick();
      rst_n = 1'b1;
      m_st = 0;
      model_home();
      tick();
      snap("reset_mid_step", 0, 20, 15, 0);

      for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: got no event, required st=%0d head=(%0d,%0d) step=%0b",
                  e.tag, e.st, e.hx, e.hy, e.stp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
